// File: rtl/gpio_axil_pkg.sv
// Shared definitions for the multi-channel AXI4-Lite GPIO: register map, response codes, decode helpers.
package gpio_axil_pkg;

  localparam int unsigned AXI_DW = 32;

  localparam logic [5:0] OFF_GIE = 6'h20;
  localparam logic [5:0] OFF_IER = 6'h24;
  localparam logic [5:0] OFF_ISR = 6'h28;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    CTRL_NONE,
    CTRL_GIE,
    CTRL_IER,
    CTRL_ISR
  } ctrl_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] ch;
    logic       is_tri;
    ctrl_e      ctrl_sel;
  } dec_t;

  // Word index (byte address [5:2]) to register target; channel words occupy 0..2*num_ch-1.
  function automatic dec_t addr_decode(input logic [3:0] word, input int unsigned num_ch);
    dec_t d;
    d = '0;
    if (32'(word) < 2 * num_ch) begin
      d.hit    = 1'b1;
      d.ch     = word[2:1];
      d.is_tri = word[0];
    end else if (word == OFF_GIE[5:2]) begin
      d.hit      = 1'b1;
      d.ctrl_sel = CTRL_GIE;
    end else if (word == OFF_IER[5:2]) begin
      d.hit      = 1'b1;
      d.ctrl_sel = CTRL_IER;
    end else if (word == OFF_ISR[5:2]) begin
      d.hit      = 1'b1;
      d.ctrl_sel = CTRL_ISR;
    end
    return d;
  endfunction

  function automatic logic [AXI_DW-1:0] apply_strb(input logic [AXI_DW-1:0] old_v,
                                                   input logic [AXI_DW-1:0] new_v,
                                                   input logic [3:0]        strb);
    logic [AXI_DW-1:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_axil_multi_sync.sv
// Per-channel input synchroniser with a history register and a direction-masked edge flag.
module gpio_sync_edge #(
  parameter int unsigned W           = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] pin_i,
  input  logic [W-1:0] tri_i,
  output logic [W-1:0] sync_o,
  output logic         edge_o_c
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]                  prev_q;

  // prev_q follows every bit regardless of direction, so a direction flip alone raises no edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign edge_o_c = |((sync_q[SYNC_STAGES-1] ^ prev_q) & tri_i);

endmodule

// File: rtl/gpio_axil_multi.sv
// AXI4-Lite GPIO controller: NUM_CH channels with per-bit direction, sticky edge ISR and level irq.
module gpio_axil_multi
  import gpio_axil_pkg::*;
#(
  parameter int unsigned            C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned            C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned            NUM_CH             = 2,
  parameter int unsigned            GPIO_WIDTH         = 32,
  parameter int unsigned            SYNC_STAGES        = 2,
  parameter logic [GPIO_WIDTH-1:0]  DEFAULT_OUT        = '0,
  parameter logic [GPIO_WIDTH-1:0]  DEFAULT_TRI        = '1
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  input  logic [NUM_CH*GPIO_WIDTH-1:0]     gpio_i,
  output logic [NUM_CH*GPIO_WIDTH-1:0]     gpio_o,
  output logic [NUM_CH*GPIO_WIDTH-1:0]     gpio_t,
  output logic                             irq
);

  localparam int unsigned CW = GPIO_WIDTH;

  logic [NUM_CH-1:0][CW-1:0] data_q, data_d, tri_q, tri_d, sync_val;
  logic [NUM_CH-1:0]         ier_q, ier_d, isr_q, isr_d, edge_c;
  logic                      gie_q, gie_d, irq_q, irq_d;
  logic                      awready_q, awready_d, bvalid_q, bvalid_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d;
  resp_e                     bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXI_DW-1:0]         rdata_q, rdata_d, rdmux_c;
  logic                      wr_hs_c, rd_hs_c;
  dec_t                      wdec_c, rdec_c;
  logic                      unused_c;

  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gpio_sync_edge #(.W(CW), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (S_AXI_ACLK),
      .rst_i    (S_AXI_ARESET),
      .pin_i    (gpio_i[c*CW +: CW]),
      .tri_i    (tri_q[c]),
      .sync_o   (sync_val[c]),
      .edge_o_c (edge_c[c])
    );
  end

  assign wdec_c  = addr_decode(S_AXI_AWADDR[5:2], NUM_CH);
  assign rdec_c  = addr_decode(S_AXI_ARADDR[5:2], NUM_CH);
  assign wr_hs_c = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs_c = arready_q && S_AXI_ARVALID;

  // Read mux: input bits return the synchronised pin, output bits the output register
  always_comb begin
    rdmux_c = '0;
    if (rdec_c.hit) begin
      case (rdec_c.ctrl_sel)
        CTRL_GIE: rdmux_c = AXI_DW'(gie_q);
        CTRL_IER: rdmux_c = AXI_DW'(ier_q);
        CTRL_ISR: rdmux_c = AXI_DW'(isr_q);
        default: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (rdec_c.ch == 2'(c)) begin
              rdmux_c = rdec_c.is_tri ? AXI_DW'(tri_q[c])
                                      : AXI_DW'((tri_q[c] & sync_val[c]) | (~tri_q[c] & data_q[c]));
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
    arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    data_d    = data_q;
    tri_d     = tri_q;
    gie_d     = gie_q;
    ier_d     = ier_q;
    isr_d     = isr_q;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_hs_c) begin
      bvalid_d = 1'b1;
      bresp_d  = wdec_c.hit ? RESP_OKAY : RESP_SLVERR;
    end
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_hs_c) begin
      rvalid_d = 1'b1;
      rresp_d  = rdec_c.hit ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rdmux_c;
    end

    if (wr_hs_c && wdec_c.hit) begin
      case (wdec_c.ctrl_sel)
        CTRL_GIE: if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
        CTRL_IER: if (S_AXI_WSTRB[0]) ier_d = S_AXI_WDATA[NUM_CH-1:0];
        CTRL_ISR: if (S_AXI_WSTRB[0]) isr_d = isr_q & ~S_AXI_WDATA[NUM_CH-1:0];
        default: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (wdec_c.ch == 2'(c)) begin
              if (wdec_c.is_tri)
                tri_d[c] = CW'(apply_strb(AXI_DW'(tri_q[c]), S_AXI_WDATA, S_AXI_WSTRB));
              else
                data_d[c] = CW'(apply_strb(AXI_DW'(data_q[c]), S_AXI_WDATA, S_AXI_WSTRB));
            end
          end
        end
      endcase
    end
    // A fresh edge wins over a W1C landing on the same edge
    isr_d = isr_d | edge_c;
    irq_d = gie_q & |(isr_q & ier_q);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      data_q    <= {NUM_CH{DEFAULT_OUT}};
      tri_q     <= {NUM_CH{DEFAULT_TRI}};
      gie_q     <= 1'b0;
      ier_q     <= '0;
      isr_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      awready_q <= awready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      data_q    <= data_d;
      tri_q     <= tri_d;
      gie_q     <= gie_d;
      ier_q     <= ier_d;
      isr_q     <= isr_d;
      irq_q     <= irq_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign gpio_o        = data_q;
  assign gpio_t        = tri_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_axil_multi.sv
// Self-checking bench for gpio_axil_multi (2 channels x 8 bits): vector table plus handshake/irq sequences.
module tb_gpio_axil_multi;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] gpio_i = '0, gpio_o, gpio_t;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } rd_exp_t;

  logic [1:0] wr_exp_q[$];
  rd_exp_t    rd_exp_q[$];

  typedef struct {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [15:0] pins;
  } vec_t;

  vec_t vecs[$];

  gpio_axil_multi #(
    .NUM_CH(2), .GPIO_WIDTH(8), .SYNC_STAGES(2)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_start(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_r);
    wr_exp_q.push_back(exp_r);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic wr_finish();
    int n;
    logic [1:0] e;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL wr_aw_timeout: got no AWREADY/WREADY, expected within 20 cycles");
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    e = wr_exp_q.pop_front();
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL wr_b_timeout: got no BVALID, expected within 20 cycles");
    end else check("bresp", 32'(bresp), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_r);
    @(negedge clk);
    wr_start(a, d, s, exp_r);
    wr_finish();
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n;
    rd_exp_t e;
    rd_exp_q.push_back('{exp_d, exp_r});
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL rd_ar_timeout: got no ARREADY, expected within 20 cycles");
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    e = rd_exp_q.pop_front();
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL rd_r_timeout: got no RVALID, expected within 20 cycles");
    end else begin
      check($sformatf("rdata@%02h", a), rdata, e.d);
      check($sformatf("rresp@%02h", a), 32'(rresp), 32'(e.r));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n, hold, extra;

    // reset values, fresh map reads, ch0 mixed direction, strobes, ISR clear, decode errors
    vecs.push_back('{1'b0, 6'h00, 32'h0, 4'hF, 32'h00, OK, 16'h0000});
    vecs.push_back('{1'b0, 6'h04, 32'h0, 4'hF, 32'hFF, OK, 16'h0000});
    vecs.push_back('{1'b0, 6'h08, 32'h0, 4'hF, 32'h00, OK, 16'h0000});
    vecs.push_back('{1'b0, 6'h0C, 32'h0, 4'hF, 32'hFF, OK, 16'h0000});
    vecs.push_back('{1'b0, 6'h20, 32'h0, 4'hF, 32'h00, OK, 16'h0000});
    vecs.push_back('{1'b0, 6'h24, 32'h0, 4'hF, 32'h00, OK, 16'h0000});
    vecs.push_back('{1'b0, 6'h28, 32'h0, 4'hF, 32'h00, OK, 16'h0000});
    vecs.push_back('{1'b1, 6'h04, 32'h0F, 4'hF, 32'h0, OK, 16'h003C});
    vecs.push_back('{1'b1, 6'h00, 32'hA5, 4'hF, 32'h0, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h00, 32'h0, 4'hF, 32'hAC, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h04, 32'h0, 4'hF, 32'h0F, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h28, 32'h0, 4'hF, 32'h01, OK, 16'h003C});
    vecs.push_back('{1'b1, 6'h28, 32'hFF, 4'hF, 32'h0, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h28, 32'h0, 4'hF, 32'h00, OK, 16'h003C});
    vecs.push_back('{1'b1, 6'h08, 32'h11223344, 4'h1, 32'h0, OK, 16'h003C});
    vecs.push_back('{1'b1, 6'h0C, 32'h00, 4'hF, 32'h0, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h08, 32'h0, 4'hF, 32'h44, OK, 16'h003C});
    vecs.push_back('{1'b1, 6'h0C, 32'hFF, 4'hF, 32'h0, OK, 16'h003C});
    vecs.push_back('{1'b1, 6'h2C, 32'hFFFFFFFF, 4'hF, 32'h0, SE, 16'h003C});
    vecs.push_back('{1'b0, 6'h3C, 32'h0, 4'hF, 32'h00, SE, 16'h003C});
    vecs.push_back('{1'b0, 6'h10, 32'h0, 4'hF, 32'h00, SE, 16'h003C});
    vecs.push_back('{1'b0, 6'h00, 32'h0, 4'hF, 32'hAC, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h0C, 32'h0, 4'hF, 32'hFF, OK, 16'h003C});
    vecs.push_back('{1'b0, 6'h28, 32'h0, 4'hF, 32'h00, OK, 16'h003C});

    repeat (2) @(negedge clk);
    check("rst_awready", 32'(awready), 32'h0);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_gpio_o", 32'(gpio_o), 32'h0000);
    check("rst_gpio_t", 32'(gpio_t), 32'hFFFF);
    rst = 1'b0;

    foreach (vecs[i]) begin
      gpio_i = vecs[i].pins;
      if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_r);
      else               axi_read(vecs[i].addr, vecs[i].exp_d, vecs[i].exp_r);
    end
    check("tbl_gpio_o", 32'(gpio_o), 32'h44A5);
    check("tbl_gpio_t", 32'(gpio_t), 32'hFF0F);
    check("tbl_irq", 32'(irq), 32'h0);

    // edge on ch1 bit 0 reaches irq within SYNC_STAGES+2 cycles
    axi_write(6'h20, 32'h1, 4'hF, OK);
    axi_write(6'h24, 32'h2, 4'hF, OK);
    @(negedge clk);
    gpio_i[8] = ~gpio_i[8];
    n = 0;
    while (!irq && n < 10) begin @(negedge clk); n++; end
    check("irq_set", 32'(irq), 32'h1);
    check("irq_latency_ok", 32'(n <= 4), 32'h1);
    axi_read(6'h28, 32'h2, OK);
    axi_write(6'h28, 32'h2, 4'hF, OK);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);
    axi_read(6'h28, 32'h0, OK);

    // re-arm, then time a new edge to land on the same clock as the W1C
    @(negedge clk);
    gpio_i[8] = ~gpio_i[8];
    repeat (6) @(negedge clk);
    axi_read(6'h28, 32'h2, OK);
    @(negedge clk);
    gpio_i[8] = ~gpio_i[8];
    @(negedge clk);
    wr_start(6'h28, 32'h2, 4'hF, OK);
    wr_finish();
    axi_read(6'h28, 32'h2, OK);
    check("irq_after_race", 32'(irq), 32'h1);

    // AW alone stalls; B held by master while a read completes
    @(negedge clk);
    bready = 1'b0;
    awaddr = 6'h00; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1'b1;
    wr_exp_q.push_back(OK);
    extra = 0;
    repeat (5) begin @(negedge clk); if (awready || wready) extra++; end
    check("aw_only_stall", 32'(extra), 32'h0);
    wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    check("aw_w_accept", 32'(awready && wready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    axi_read(6'h04, 32'h0F, OK);
    hold = 0; extra = 0;
    repeat (10) begin @(negedge clk); if (bvalid) hold++; if (awready) extra++; end
    check("bvalid_held", 32'(hold), 32'd10);
    check("no_second_accept", 32'(extra), 32'h0);
    bready = 1'b1;
    check("bresp_held", 32'(bresp), 32'(wr_exp_q.pop_front()));
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_dropped", 32'(bvalid), 32'h0);
    check("held_wr_gpio_o", 32'(gpio_o[7:0]), 32'h5A);
    axi_read(6'h00, 32'h5C, OK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
